// File: rtl/usb_up_arbiter.sv
// usb_up_arbiter
//   Packet-level scheduler sharing the FX2 slave-FIFO upload port between the
//   IQ sample FIFO (source 0) and the status/telemetry FIFO (source 1).
//   A source is eligible when enabled and holding at least one full packet.
//   When both sources are eligible, they are served round-robin.
//   Exactly one source owns each packet. Grants beyond PKT_WORDS are swallowed,
//   so a source FIFO can never underflow.
//
//   Optional feature macro: UP_ARB_WDOG_EN
//     This macro enables a transfer watchdog, controlled by TMO_CYC.
//     When the macro is undefined, tmo_err is tied low.
//
// Ports
//   clk_24m            sole clock
//   rst_n              synchronous active-low reset
//   src_en[1:0]        per-source enable (bit0 IQ, bit1 status)
//   s0/s1_usedw        source FIFO fill levels
//   s0/s1_rdreq        read strobes to the show-ahead source FIFOs
//   s0/s1_dat          source FIFO heads
//   up_req             packet request to fx2
//   up_grant           fx2 consumes up_dat this cycle
//   up_dat             muxed upload data
//   up_fin             fx2 packet-complete pulse
//   cur_src            source owning the current or last packet
//   busy               high while transferring or in the inter-packet gap
//   pkt_cnt0/1         completed-packet counters (wrapping)
//   len_err            sticky: a packet ended with grant count != PKT_WORDS
//   tmo_err            sticky watchdog flag (0 without the watchdog)
module usb_up_arbiter #(
  parameter int PKT_WORDS = 256,
  parameter int CNT_W     = 10
`ifdef UP_ARB_WDOG_EN
  , parameter int TMO_CYC = 8192
`endif
) (
  input  logic             clk_24m,
  input  logic             rst_n,
  input  logic [1:0]       src_en,
  input  logic [CNT_W-1:0] s0_usedw,
  input  logic [CNT_W-1:0] s1_usedw,
  output logic             s0_rdreq,
  output logic             s1_rdreq,
  input  logic [15:0]      s0_dat,
  input  logic [15:0]      s1_dat,
  output logic             up_req,
  input  logic             up_grant,
  output logic [15:0]      up_dat,
  input  logic             up_fin,
  output logic             cur_src,
  output logic             busy,
  output logic [15:0]      pkt_cnt0,
  output logic [15:0]      pkt_cnt1,
  output logic             len_err,
  output logic             tmo_err
);

  // The word counter must be able to represent PKT_WORDS+1 ("too many"),
  // so over-long packets are still flagged once forwarding has stopped.
  localparam int WCNT_W = $clog2(PKT_WORDS + 2);
  localparam logic [CNT_W-1:0]  USED_THR = CNT_W'(PKT_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_LIM = WCNT_W'(PKT_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_OVR = WCNT_W'(PKT_WORDS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP} state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [15:0]       pkt_cnt0_q, pkt_cnt0_d;
  logic [15:0]       pkt_cnt1_q, pkt_cnt1_d;
  logic              len_err_q, len_err_d;
  logic              up_req_q, up_req_d;
  logic              busy_q, busy_d;

  logic [1:0]        elig;
  logic              in_xfer;
  logic              fwd;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              timeout;

`ifdef UP_ARB_WDOG_EN
  localparam int TMO_W = (($clog2(TMO_CYC + 1)) > 13) ? $clog2(TMO_CYC + 1) : 13;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;

  // The count restarts on every grant.
  // Hitting the limit on a cycle without a grant ends the packet.
  always_comb begin
    tmo_cnt_d = '0;
    if (in_xfer && !up_grant) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    timeout   = in_xfer && !up_grant && (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
    tmo_err_d = tmo_err_q || (timeout && !up_fin);
  end

  always_ff @(posedge clk_24m) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign tmo_err = tmo_err_q;
`else
  assign timeout = 1'b0;
  assign tmo_err = 1'b0;
`endif

  always_comb begin
    elig[0]  = src_en[0] && (s0_usedw >= USED_THR);
    elig[1]  = src_en[1] && (s1_usedw >= USED_THR);
    in_xfer  = (state_q == ST_XFER);
    fwd      = in_xfer && up_grant && (wcnt_q < WCNT_LIM);
    // Count every grant, including grants that are not forwarded.
    // Saturate at "one too many".
    wcnt_inc = wcnt_q;
    if (in_xfer && up_grant && (wcnt_q != WCNT_OVR)) begin
      wcnt_inc = wcnt_q + 1'b1;
    end

    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    wcnt_d     = wcnt_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    len_err_d  = len_err_q;

    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          // If both sources are eligible, prefer the source that did not send last.
          sel_d   = (elig == 2'b11) ? ~last_q : elig[1];
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        wcnt_d = wcnt_inc;
        if (up_fin) begin
          state_d = ST_GAP;
          last_d  = sel_q;
          if (sel_q) pkt_cnt1_d = pkt_cnt1_q + 16'd1;
          else       pkt_cnt0_d = pkt_cnt0_q + 16'd1;
          if (wcnt_inc != WCNT_LIM) len_err_d = 1'b1;
        end else if (timeout) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        wcnt_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    up_req_d = (state_d == ST_XFER);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_24m) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      wcnt_q     <= '0;
      pkt_cnt0_q <= 16'd0;
      pkt_cnt1_q <= 16'd0;
      len_err_q  <= 1'b0;
      up_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      wcnt_q     <= wcnt_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
      len_err_q  <= len_err_d;
      up_req_q   <= up_req_d;
      busy_q     <= busy_d;
    end
  end

  // Data and read strobes follow up_grant with no added latency.
  assign up_dat   = sel_q ? s1_dat : s0_dat;
  assign s0_rdreq = fwd && !sel_q;
  assign s1_rdreq = fwd &&  sel_q;
  assign up_req   = up_req_q;
  assign busy     = busy_q;
  assign cur_src  = sel_q;
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_usb_up_arbiter.sv
// tb_usb_up_arbiter
//   Bench for usb_up_arbiter. The bench models the fx2 upload side and two
//   show-ahead source FIFOs. A packet-level reference model predicts the
//   following for each packet:
//     - the owning source,
//     - the number of forwarded words,
//     - the counters and the sticky length flag.
//   Predictions are queued when the packet is issued. A monitor pops a
//   prediction each time a completed-packet counter moves.
module tb_usb_up_arbiter;
  localparam int PKT = 256;

  logic        clk_24m = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  src_en = 2'b00;
  logic [9:0]  s0_usedw = '0;
  logic [9:0]  s1_usedw = '0;
  logic        s0_rdreq, s1_rdreq;
  logic [15:0] s0_dat = 16'h0000;
  logic [15:0] s1_dat = 16'h8000;
  logic        up_req;
  logic        up_grant = 1'b0;
  logic [15:0] up_dat;
  logic        up_fin = 1'b0;
  logic        cur_src, busy;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic        len_err, tmo_err;

  usb_up_arbiter dut (
    .clk_24m (clk_24m),
    .rst_n   (rst_n),
    .src_en  (src_en),
    .s0_usedw(s0_usedw),
    .s1_usedw(s1_usedw),
    .s0_rdreq(s0_rdreq),
    .s1_rdreq(s1_rdreq),
    .s0_dat  (s0_dat),
    .s1_dat  (s1_dat),
    .up_req  (up_req),
    .up_grant(up_grant),
    .up_dat  (up_dat),
    .up_fin  (up_fin),
    .cur_src (cur_src),
    .busy    (busy),
    .pkt_cnt0(pkt_cnt0),
    .pkt_cnt1(pkt_cnt1),
    .len_err (len_err),
    .tmo_err (tmo_err)
  );

  always #20 clk_24m = ~clk_24m;

  // Show-ahead FIFO heads: the next word appears after each read strobe.
  always @(posedge clk_24m) begin
    if (s0_rdreq === 1'b1) s0_dat <= s0_dat + 16'd1;
    if (s1_rdreq === 1'b1) s1_dat <= s1_dat + 16'd1;
  end

  typedef struct {
    int src;
    int rd0;
    int rd1;
    int cnt0;
    int cnt1;
    bit lerr;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  // Reference model state
  int   m_last = 1;
  int   m_cnt[2] = '{0, 0};
  bit   m_lerr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Predict the next packet from the configuration the DUT will see in IDLE.
  task automatic expect_pkt(input int n_grants);
    exp_t e;
    bit   e0, e1;
    int   src;
    e0 = src_en[0] && (s0_usedw >= PKT);
    e1 = src_en[1] && (s1_usedw >= PKT);
    if (!e0 && !e1) begin
      checks++;
      errors++;
      $display("FAIL expect_pkt: eligible=0 expected 1 (stimulus has no eligible source)");
    end
    src = (e0 && e1) ? 1 - m_last : (e1 ? 1 : 0);
    m_last = src;
    m_cnt[src] = (m_cnt[src] + 1) % 65536;
    if (n_grants != PKT) m_lerr = 1'b1;
    e.src  = src;
    e.rd0  = (src == 0) ? ((n_grants < PKT) ? n_grants : PKT) : 0;
    e.rd1  = (src == 1) ? ((n_grants < PKT) ? n_grants : PKT) : 0;
    e.cnt0 = m_cnt[0];
    e.cnt1 = m_cnt[1];
    e.lerr = m_lerr;
    sb_q.push_back(e);
  endtask

  task automatic wait_req();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_24m);
      if (up_req === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_req: up_req=0 expected 1 within 200 cycles");
    end
  endtask

  // fx2 model: n grants with random idle cycles, then up_fin (with or after the last grant)
  task automatic drive_pkt(input int n, input bit fin_with_grant, input bit drop_en);
    int issued = 0;
    wait_req();
    @(posedge clk_24m); #1;
    if (drop_en) src_en = 2'b00;
    while (issued < n) begin
      if ($urandom_range(0, 3) == 0) begin
        up_grant = 1'b0;
      end else begin
        up_grant = 1'b1;
        issued++;
        if (issued == n && fin_with_grant) up_fin = 1'b1;
      end
      @(posedge clk_24m); #1;
    end
    if (!fin_with_grant) begin
      up_grant = 1'b0;
      up_fin   = 1'b1;
      @(posedge clk_24m); #1;
    end
    up_grant = 1'b0;
    up_fin   = 1'b0;
  endtask

  // Monitor: checks every forwarded word and each completed packet
  initial begin
    logic [15:0] seen0, seen1;
    int acc0, acc1, low_run;
    exp_t e;
    seen0 = '0; seen1 = '0; acc0 = 0; acc1 = 0; low_run = 100;
    forever begin
      @(negedge clk_24m);
      if (rst_n !== 1'b1) begin
        acc0 = 0; acc1 = 0; seen0 = '0; seen1 = '0; low_run = 100;
      end else if (mon_en) begin
        if (s0_rdreq === 1'b1 && s1_rdreq === 1'b1) begin
          checks++; errors++;
          $display("FAIL both_rdreq: got s0=1 s1=1 expected at most one");
        end
        if (s0_rdreq === 1'b1) begin
          acc0++;
          check("rd0_cur_src", cur_src, 0);
          check("rd0_data", up_dat, s0_dat);
        end
        if (s1_rdreq === 1'b1) begin
          acc1++;
          check("rd1_cur_src", cur_src, 1);
          check("rd1_data", up_dat, s1_dat);
        end
        if (up_req === 1'b1) begin
          if (low_run != 0) begin
            checks++;
            if (low_run < 2) begin
              errors++;
              $display("FAIL req_gap: got %0d low cycles expected >=2", low_run);
            end
          end
          low_run = 0;
        end else begin
          low_run++;
        end
        if (pkt_cnt0 !== seen0 || pkt_cnt1 !== seen1) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pkt: got cnt0=%0d cnt1=%0d expected no packet", pkt_cnt0, pkt_cnt1);
          end else begin
            e = sb_q.pop_front();
            check("pkt_src", cur_src, e.src);
            check("pkt_rd0", acc0, e.rd0);
            check("pkt_rd1", acc1, e.rd1);
            check("pkt_cnt0", pkt_cnt0, e.cnt0);
            check("pkt_cnt1", pkt_cnt1, e.cnt1);
            check("pkt_len_err", len_err, e.lerr);
            $display("pkt src=%0d rd0=%0d rd1=%0d cnt0=%0d cnt1=%0d len_err=%0d",
                     cur_src, acc0, acc1, pkt_cnt0, pkt_cnt1, len_err);
          end
          acc0 = 0; acc1 = 0;
          seen0 = pkt_cnt0; seen1 = pkt_cnt1;
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_24m);
    @(negedge clk_24m);
    check("rst_up_req", up_req, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_src", cur_src, 0);
    check("rst_pkt_cnt0", pkt_cnt0, 0);
    check("rst_pkt_cnt1", pkt_cnt1, 0);
    check("rst_len_err", len_err, 0);
    check("rst_tmo_err", tmo_err, 0);
    check("rst_rdreq", {s1_rdreq, s0_rdreq}, 0);
    check("rst_up_dat", up_dat, s0_dat);
    @(posedge clk_24m); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Reset during a transfer after 100 grants
    src_en = 2'b01; s0_usedw = 10'd256;
    wait_req();
    @(posedge clk_24m); #1;
    repeat (100) begin
      up_grant = 1'b1;
      @(posedge clk_24m); #1;
    end
    up_grant = 1'b0; src_en = 2'b00; rst_n = 1'b0;
    @(posedge clk_24m);
    @(negedge clk_24m);
    check("midrst_up_req", up_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pkt_cnt0", pkt_cnt0, 0);
    check("midrst_cur_src", cur_src, 0);
    @(posedge clk_24m); #1;
    rst_n = 1'b1;
    $display("reset mid-transfer: up_req=%0d pkt_cnt0=%0d", up_req, pkt_cnt0);

    // Round robin, both sources eligible
    src_en = 2'b11; s0_usedw = 10'd300; s1_usedw = 10'd256;
    repeat (4) begin
      expect_pkt(PKT);
      drive_pkt(PKT, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Single source, exact packet
    src_en = 2'b01; s0_usedw = 10'd256; s1_usedw = 10'd512;
    expect_pkt(PKT);
    drive_pkt(PKT, 1'b0, 1'b0);

    // Threshold: 255 words is not enough; 256 words requests on the next edge
    s0_usedw = 10'd255;
    repeat (8) begin
      @(negedge clk_24m);
      check("below_thr_up_req", up_req, 0);
    end
    @(posedge clk_24m); #1;
    s0_usedw = 10'd256;
    @(posedge clk_24m);
    @(negedge clk_24m);
    check("at_thr_up_req", up_req, 1);
    $display("threshold: up_req=%0d one cycle after usedw=256", up_req);
    expect_pkt(PKT);
    drive_pkt(PKT, 1'b1, 1'b0);

    // Over-long packet, then short packet with fin on the last grant
    expect_pkt(260);
    drive_pkt(260, 1'b0, 1'b0);
    expect_pkt(200);
    drive_pkt(200, 1'b1, 1'b0);

    // Randomized traffic
    repeat (10) begin
      int n;
      src_en   = 2'($urandom_range(1, 3));
      s0_usedw = 10'($urandom_range(200, 400));
      s1_usedw = 10'($urandom_range(200, 400));
      if (src_en[0] && s0_usedw < 10'd256) s0_usedw = 10'd256 + 10'($urandom_range(0, 100));
      if (src_en[1] && s1_usedw < 10'd256) s1_usedw = 10'd256 + 10'($urandom_range(0, 100));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(180, 300)) : PKT;
      expect_pkt(n);
      drive_pkt(n, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    src_en = 2'b00;
    repeat (6) @(negedge clk_24m);
    check("scoreboard_empty", sb_q.size(), 0);
    check("final_tmo_err", tmo_err, 0);
    check("final_len_err", len_err, m_lerr);
    check("final_up_req", up_req, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
